// File: rtl/avr_fetch_unit_pkg.sv
// Shared constants and helpers for the AVR instruction prefetch path.
// The 32-bit opcode patterns are also consumed by the core decoder.
package avr_fetch_unit_pkg;

    localparam int unsigned FlashAwDefault = 14;

    localparam logic [15:0] JmpCallMask = 16'hFE0E;
    localparam logic [15:0] JmpMatch    = 16'h940C;
    localparam logic [15:0] CallMatch   = 16'h940E;
    localparam logic [15:0] LdsStsMask  = 16'hFC0F;
    localparam logic [15:0] LdsStsMatch = 16'h9000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } fetch_entry_t;

    // FLASH stores words low byte first relative to the decoder's view.
    function automatic logic [15:0] byte_swap(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic is_32bit(input logic [15:0] w);
        return ((w & JmpCallMask) == JmpMatch) ||
               ((w & JmpCallMask) == CallMatch) ||
               ((w & LdsStsMask) == LdsStsMatch);
    endfunction

endpackage

// File: rtl/avr_fetch_queue.sv
// Prefetch FIFO of {pc, word}; pops one or two entries per cycle and exposes
// the head and the entry behind it so a 32-bit instruction can be presented whole.
module avr_fetch_queue
    import avr_fetch_unit_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [15:0]              push_pc_i,
    input  logic [15:0]              push_word_i,
    input  logic                     pop1_i,
    input  logic                     pop2_i,
    input  logic                     flush_i,
    output logic [$clog2(Depth):0]   count_o,
    output logic [15:0]              head_pc_o,
    output logic [15:0]              head_word_o,
    output logic [15:0]              head_next_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] nxt_ptr;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] pop_cnt;

    always_comb begin
        pop_cnt  = pop2_i ? CntW'(2) : (pop1_i ? CntW'(1) : '0);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_cnt);
        wr_ptr_d = wr_ptr_q + PtrW'(push_i);
        count_d  = count_q + CntW'(push_i) - pop_cnt;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count_q are ever observed.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc_i, word: push_word_i};
        end
    end

    assign nxt_ptr     = rd_ptr_q + PtrW'(1);
    assign count_o     = count_q;
    assign head_pc_o   = mem_q[rd_ptr_q].pc;
    assign head_word_o = mem_q[rd_ptr_q].word;
    assign head_next_o = mem_q[nxt_ptr].word;

endmodule

// File: rtl/avr_fetch_unit.sv
// Instruction prefetch stage: streams FLASH words into a small queue and hands
// complete 16/32-bit AVR instructions to the core over valid/ready.
module avr_fetch_unit
    import avr_fetch_unit_pkg::*;
#(
    parameter int unsigned FLASH_AW    = FlashAwDefault,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    output logic [FLASH_AW-1:0] flash_addr_o,
    output logic                flash_rd_o,
    input  logic [15:0]         flash_q_i,
    input  logic                redirect_valid_i,
    input  logic [15:0]         redirect_pc_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [15:0]         instr_word1_o,
    output logic [15:0]         instr_word2_o,
    output logic [15:0]         instr_pc_o,
    output logic                instr_is32_o
);

    localparam int unsigned    CntW     = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CntW:0]  DepthLim = (CntW + 1)'(QUEUE_DEPTH);

    logic [FLASH_AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [FLASH_AW-1:0] rtn_pc_q, rtn_pc_d;
    logic                inflight_q, inflight_d;

    logic                issue, push, pop;
    logic                has_one, head_32raw;
    logic [CntW-1:0]     count;
    logic [CntW:0]       credit_used;
    logic [15:0]         head_pc, head_word, head_next;
    logic                unused_redirect_hi;

    assign unused_redirect_hi = ^redirect_pc_i[15:FLASH_AW];

    // A word in flight already owns a queue slot, so a full queue can never overflow.
    assign credit_used = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
    assign issue       = !reset_i && !redirect_valid_i && (credit_used < DepthLim);
    assign push        = inflight_q && !redirect_valid_i;

    assign has_one     = (count != '0);
    assign head_32raw  = is_32bit(head_word);

    always_comb begin
        instr_valid_o = has_one && (!head_32raw || (count >= CntW'(2)));
        instr_is32_o  = has_one && head_32raw;
        instr_word1_o = has_one ? head_word : 16'h0000;
        instr_pc_o    = has_one ? head_pc : 16'h0000;
        instr_word2_o = (instr_is32_o && count >= CntW'(2)) ? head_next : 16'h0000;
    end

    assign pop          = instr_valid_o && instr_ready_i && !redirect_valid_i;
    assign flash_rd_o   = issue;
    assign flash_addr_o = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rtn_pc_d   = rtn_pc_q;
        inflight_d = issue;
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i[FLASH_AW-1:0];
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + FLASH_AW'(1);
            rtn_pc_d   = fetch_pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q <= '0;
            rtn_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rtn_pc_q   <= rtn_pc_d;
            inflight_q <= inflight_d;
        end
    end

    avr_fetch_queue #(
        .Depth (QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_pc_i   (16'(rtn_pc_q)),
        .push_word_i (byte_swap(flash_q_i)),
        .pop1_i      (pop && !instr_is32_o),
        .pop2_i      (pop && instr_is32_o),
        .flush_i     (redirect_valid_i),
        .count_o     (count),
        .head_pc_o   (head_pc),
        .head_word_o (head_word),
        .head_next_o (head_next)
    );

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Self-checking bench for avr_fetch_unit: directed scenarios plus a randomized
// stream checked against a program-order model of the FLASH contents.
module tb_avr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] flash_addr;
    logic        flash_rd;
    logic [15:0] flash_q = 16'h0000;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_word1, instr_word2, instr_pc;
    logic        instr_is32;

    int total = 0;
    int bad = 0;

    logic [15:0] mem [16384];

    avr_fetch_unit #(
        .FLASH_AW    (14),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .flash_addr_o     (flash_addr),
        .flash_rd_o       (flash_rd),
        .flash_q_i        (flash_q),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_word1_o    (instr_word1),
        .instr_word2_o    (instr_word2),
        .instr_pc_o       (instr_pc),
        .instr_is32_o     (instr_is32)
    );

    always #5 clk = ~clk;

    // Synchronous FLASH: data valid one cycle after the read is issued.
    always @(posedge clk) begin
        if (flash_rd) flash_q <= mem[flash_addr];
    end

    function automatic logic [15:0] m_swap(input logic [15:0] q);
        return {q[7:0], q[15:8]};
    endfunction

    function automatic bit m_is32(input logic [15:0] w);
        return ((w & 16'hFE0E) == 16'h940C) || ((w & 16'hFE0E) == 16'h940E) ||
               ((w & 16'hFC0F) == 16'h9000);
    endfunction

    function automatic logic [13:0] m_next(input logic [13:0] pc);
        return pc + (m_is32(m_swap(mem[pc])) ? 14'd2 : 14'd1);
    endfunction

    function automatic logic [15:0] rand_short();
        logic [15:0] w;
        w = 16'($urandom);
        if (m_is32(m_swap(w))) w = 16'h0000;
        return w;
    endfunction

    function automatic logic [15:0] rand_any();
        logic [31:0] r;
        logic [15:0] w;
        r = $urandom;
        if (r[31:30] == 2'b00) w = 16'h940C | (r[15:0] & 16'h01F3);
        else w = r[15:0];
        return m_swap(w);
    endfunction

    task automatic do_reset(input bit rdy);
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = rdy;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        mem[0] = 16'hEF0F;
        mem[1] = 16'hE000;
        mem[2] = 16'h0000;
        mem[3] = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        total++; if (flash_rd !== 1'b0) begin bad++; $display("FAIL rst_flash_rd: got %b want 0", flash_rd); end
        total++; if (instr_word1 !== 16'h0) begin bad++; $display("FAIL rst_word1: got %h want 0000", instr_word1); end
        total++; if (instr_word2 !== 16'h0) begin bad++; $display("FAIL rst_word2: got %h want 0000", instr_word2); end
        total++; if (instr_pc !== 16'h0) begin bad++; $display("FAIL rst_pc: got %h want 0000", instr_pc); end
        total++; if (instr_is32 !== 1'b0) begin bad++; $display("FAIL rst_is32: got %b want 0", instr_is32); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            total++;
            if (flash_rd !== 1'b1 || flash_addr !== 14'(c)) begin
                bad++; $display("FAIL rst_issue[%0d]: got rd=%b addr=%h want rd=1 addr=%h", c, flash_rd, flash_addr, 14'(c));
            end
            total++;
            if (instr_valid !== (c >= 2)) begin
                bad++; $display("FAIL rst_valid_time[%0d]: got %b want %b", c, instr_valid, (c >= 2));
            end
            if (c == 2) begin
                total++;
                if (instr_word1 !== 16'h0FEF || instr_pc !== 16'h0 || instr_is32 !== 1'b0) begin
                    bad++; $display("FAIL rst_first_instr: got w1=%h pc=%h is32=%b want 0fef 0000 0", instr_word1, instr_pc, instr_is32);
                end
            end
            if (c == 3) begin
                total++;
                if (instr_word1 !== 16'h00E0 || instr_pc !== 16'h1) begin
                    bad++; $display("FAIL rst_second_instr: got w1=%h pc=%h want 00e0 0001", instr_word1, instr_pc);
                end
            end
        end
    endtask

    task automatic test_32bit();
        int hs;
        mem[0] = 16'h0C94;
        mem[1] = 16'h3412;
        mem[2] = rand_short();
        mem[3] = rand_short();
        do_reset(1'b1);
        hs = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (c == 2) begin
                total++;
                if (instr_valid !== 1'b0) begin bad++; $display("FAIL j32_half: got valid=%b want 0", instr_valid); end
            end
            if (instr_valid && instr_ready) begin
                if (hs == 0) begin
                    total++;
                    if (c != 3) begin bad++; $display("FAIL j32_latency: got cycle %0d want 3", c); end
                    total++;
                    if (instr_word1 !== 16'h940C || instr_word2 !== 16'h1234 || instr_is32 !== 1'b1 || instr_pc !== 16'h0) begin
                        bad++; $display("FAIL j32_fields: got w1=%h w2=%h is32=%b pc=%h want 940c 1234 1 0000",
                                        instr_word1, instr_word2, instr_is32, instr_pc);
                    end
                end else if (hs == 1) begin
                    total++;
                    if (instr_pc !== 16'h2 || instr_word2 !== 16'h0) begin
                        bad++; $display("FAIL j32_next: got pc=%h w2=%h want 0002 0000", instr_pc, instr_word2);
                    end
                end
                hs++;
            end
        end
        total++;
        if (hs < 2) begin bad++; $display("FAIL j32_timeout: got %0d handshakes want >=2", hs); end
    endtask

    task automatic test_backpressure();
        int rd_cnt;
        logic [15:0] got[$];
        for (int i = 0; i < 8; i++) mem[i] = rand_short();
        do_reset(1'b0);
        rd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (flash_rd) rd_cnt++;
        end
        total++;
        if (rd_cnt != 4) begin bad++; $display("FAIL bp_reads: got %0d want 4", rd_cnt); end
        total++;
        if (flash_rd !== 1'b0) begin bad++; $display("FAIL bp_stall: got rd=%b want 0", flash_rd); end
        @(negedge clk);
        instr_ready = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (instr_valid && got.size() < 4) got.push_back(instr_pc);
        end
        total++;
        if (got.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== 16'(i)) begin bad++; $display("FAIL bp_order[%0d]: got pc=%h want %h", i, got[i], 16'(i)); end
        end
    endtask

    task automatic test_redirect();
        logic prev_rd;
        for (int i = 0; i < 32; i++) mem[i] = rand_short();
        for (int i = 16'h100; i < 16'h104; i++) mem[i] = rand_short();
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        #1;
        prev_rd = flash_rd;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        total++;
        if (prev_rd !== 1'b1) begin bad++; $display("FAIL rd_inflight: got prev rd=%b want 1", prev_rd); end
        total++;
        if (flash_rd !== 1'b0) begin bad++; $display("FAIL rd_issue_blocked: got rd=%b want 0", flash_rd); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        for (int s = 1; s < 5; s++) begin
            if (s > 1) begin @(negedge clk); #1; end
            if (s < 3) begin
                total++;
                if (instr_valid !== 1'b0) begin bad++; $display("FAIL rd_flushed[%0d]: got valid=%b want 0", s, instr_valid); end
            end else begin
                total++;
                if (instr_valid !== 1'b1 || instr_pc !== 16'h00FD + 16'(s) ||
                    instr_word1 !== m_swap(mem[14'h00FD + 14'(s)])) begin
                    bad++; $display("FAIL rd_target[%0d]: got v=%b pc=%h w1=%h want 1 %h %h", s, instr_valid, instr_pc,
                                    instr_word1, 16'h00FD + 16'(s), m_swap(mem[14'h00FD + 14'(s)]));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] pcs[$];
        logic [15:0] w1s[$];
        mem[14'h3FFF] = rand_short();
        mem[0] = rand_short();
        mem[1] = rand_short();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h3FFF;
        instr_ready = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            if (instr_valid && pcs.size() < 2) begin
                pcs.push_back(instr_pc);
                w1s.push_back(instr_word1);
            end
        end
        total++;
        if (pcs.size() != 2) begin
            bad++; $display("FAIL wrap_timeout: got %0d instrs want 2", pcs.size());
        end else begin
            total++;
            if (pcs[0] !== 16'h3FFF || pcs[1] !== 16'h0000) begin
                bad++; $display("FAIL wrap_pcs: got %h,%h want 3fff,0000", pcs[0], pcs[1]);
            end
            total++;
            if (w1s[1] !== m_swap(mem[0])) begin
                bad++; $display("FAIL wrap_word: got %h want %h", w1s[1], m_swap(mem[0]));
            end
        end
    endtask

    task automatic test_split32();
        bit seen;
        mem[14'h10] = 16'h0E94;
        mem[14'h11] = 16'($urandom);
        mem[14'h12] = rand_short();
        mem[14'h13] = rand_short();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        instr_ready = 1'b1;
        #1;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        for (int s = 1; s < 5; s++) begin
            if (s > 1) begin @(negedge clk); #1; end
            if (s < 4) begin
                total++;
                if (instr_valid !== 1'b0) begin bad++; $display("FAIL split_half[%0d]: got valid=%b want 0", s, instr_valid); end
            end else begin
                total++;
                if (instr_valid !== 1'b1 || instr_is32 !== 1'b1 || instr_pc !== 16'h0010 ||
                    instr_word1 !== 16'h940E || instr_word2 !== m_swap(mem[14'h11])) begin
                    bad++; $display("FAIL split_instr: got v=%b is32=%b pc=%h w1=%h w2=%h want 1 1 0010 940e %h",
                                    instr_valid, instr_is32, instr_pc, instr_word1, instr_word2, m_swap(mem[14'h11]));
                end
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                seen = 1'b1;
                total++;
                if (instr_pc !== 16'h0012) begin bad++; $display("FAIL split_next: got pc=%h want 0012", instr_pc); end
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL split_next_timeout: got none want pc 0012"); end
    endtask

    task automatic test_random_stream();
        logic [13:0] exp_pc;
        logic [15:0] exp_w2;
        bit          exp32;
        int          streak, max_streak, hs;
        for (int i = 0; i < 16384; i++) mem[i] = rand_any();
        do_reset(1'b1);
        exp_pc = '0;
        streak = 0;
        max_streak = 0;
        hs = 0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) begin
                @(negedge clk);
                instr_ready = ($urandom_range(0, 9) < 7);
                redirect_valid = ($urandom_range(0, 24) == 0);
                redirect_pc = 16'($urandom);
                #1;
            end
            exp32 = m_is32(m_swap(mem[exp_pc]));
            exp_w2 = exp32 ? m_swap(mem[exp_pc + 14'd1]) : 16'h0000;
            if (instr_valid) begin
                streak = 0;
                total++;
                if (instr_pc !== 16'(exp_pc) || instr_word1 !== m_swap(mem[exp_pc]) ||
                    instr_is32 !== exp32 || instr_word2 !== exp_w2) begin
                    bad++; $display("FAIL rand_instr[%0d]: got pc=%h w1=%h w2=%h is32=%b want %h %h %h %b", c,
                                    instr_pc, instr_word1, instr_word2, instr_is32, 16'(exp_pc),
                                    m_swap(mem[exp_pc]), exp_w2, exp32);
                end
            end else if (redirect_valid) begin
                streak = 0;
            end else begin
                streak++;
                if (streak > max_streak) max_streak = streak;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc[13:0];
                streak = 0;
            end else if (instr_valid && instr_ready) begin
                exp_pc = m_next(exp_pc);
                hs++;
            end
        end
        total++;
        if (max_streak > 3) begin bad++; $display("FAIL rand_stall: got %0d idle cycles want <=3", max_streak); end
        total++;
        if (hs < 100) begin bad++; $display("FAIL rand_progress: got %0d instrs want >=100", hs); end
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0055;
        instr_ready = 1'b1;
        #1;
        total++;
        if (flash_rd !== 1'b0) begin bad++; $display("FAIL mid_rst_rd: got %b want 0", flash_rd); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0 || instr_word1 !== 16'h0 || instr_pc !== 16'h0 || instr_is32 !== 1'b0) begin
            bad++; $display("FAIL mid_rst_state: got v=%b w1=%h pc=%h is32=%b want 0 0000 0000 0",
                            instr_valid, instr_word1, instr_pc, instr_is32);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (flash_rd !== 1'b1 || flash_addr !== 14'h0) begin
            bad++; $display("FAIL mid_rst_restart: got rd=%b addr=%h want 1 0000", flash_rd, flash_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        test_reset();
        test_32bit();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_split32();
        test_random_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
